// File: rtl/exe_mul_seq_ctrl.sv
// Execute-stage sequencer: single-cycle ALU ops, fixed-latency MUL ops, registered
// result handshake towards memory, synchronous flush and a saturating stall counter.
module exe_mul_seq_ctrl #(
    parameter int MUL_LATENCY = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_is_mul,
    output logic             in_ready,
    input  logic             flush,
    output logic             mul_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel_mul,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        RESULT   = 2'd2
    } state_t;

    localparam logic [7:0] LAT = 8'(MUL_LATENCY);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       sel_mul_p1;
    logic       sel_mul_nxt;
    logic       start_p1;
    logic       accept;
    logic       stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    assign accept = in_valid & in_ready;
    assign stall  = in_valid & ~in_ready;

    // ---- stage p0 -> p1: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            sel_mul_p1 <= 1'b0;
            start_p1   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel_mul_p1 <= sel_mul_nxt;
            // in_ready is already forced low by flush, so a flushed MUL never launches
            start_p1   <= accept & in_is_mul;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sel_mul_nxt = sel_mul_p1;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
        end else begin
            unique case (state)
                IDLE, RESULT: begin
                    if (accept) begin
                        if (in_is_mul) begin
                            state_nxt   = MUL_WAIT;
                            cnt_nxt     = LAT;
                            sel_mul_nxt = 1'b1;
                        end else begin
                            state_nxt   = RESULT;
                            sel_mul_nxt = 1'b0;
                        end
                    end else if (state == RESULT && out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                MUL_WAIT: begin
                    cnt_nxt = cnt - 8'd1;
                    // <= 1 rather than == 1 so a corrupted zero count cannot wrap
                    if (cnt <= 8'd1) begin
                        state_nxt = RESULT;
                        cnt_nxt   = 8'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:     in_ready = 1'b1;
            RESULT: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            MUL_WAIT: busy = 1'b1;
            default:  in_ready = 1'b0;
        endcase
        if (flush) begin
            in_ready = 1'b0;
        end
    end

    assign mul_start   = start_p1;
    assign out_sel_mul = sel_mul_p1;

endmodule

// File: tb/tb_exe_mul_seq_ctrl.sv
// Bench for exe_mul_seq_ctrl: three instances (latency 5, latency 1, 4-bit stall counter)
// share stimulus; directed scenarios plus random traffic against a timestamp-based model.
module tb_exe_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_is_mul, flush, out_ready;
    logic [2:0] rdy, mst, ov, sel, bsy;
    logic [31:0] st0, st1;
    logic [3:0]  st2;

    exe_mul_seq_ctrl #(.MUL_LATENCY(5), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_mul(in_is_mul), .in_ready(rdy[0]),
        .flush(flush), .mul_start(mst[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_sel_mul(sel[0]), .busy(bsy[0]), .stall_cnt(st0));
    exe_mul_seq_ctrl #(.MUL_LATENCY(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_mul(in_is_mul), .in_ready(rdy[1]),
        .flush(flush), .mul_start(mst[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_sel_mul(sel[1]), .busy(bsy[1]), .stall_cnt(st1));
    exe_mul_seq_ctrl #(.MUL_LATENCY(5), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_mul(in_is_mul), .in_ready(rdy[2]),
        .flush(flush), .mul_start(mst[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_sel_mul(sel[2]), .busy(bsy[2]), .stall_cnt(st2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int     lat  [3] = '{5, 1, 5};
    longint smax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    // model: a pending MUL finishes at a recorded cycle number
    bit     m_pend [3];
    int     m_done [3];
    bit     m_res  [3];
    bit     m_rmul [3];
    bit     m_start[3];
    longint m_stall[3];

    bit     e_ready[3], e_start[3], e_valid[3], e_sel[3], e_busy[3];
    longint e_stall[3];
    bit     o_ready[3], o_start[3], o_valid[3], o_sel[3], o_busy[3];
    longint o_stall[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0; m_done[i] = 0; m_res[i] = 0; m_rmul[i] = 0;
            m_start[i] = 0; m_stall[i] = 0;
        end
    endtask

    task automatic step(input bit v, input bit m, input bit f, input bit r, input bit rs = 1'b1);
        bit acc;
        @(negedge clk);
        rst = rs; in_valid = v; in_is_mul = m; flush = f; out_ready = r;
        #1;
        if (!rs) model_reset();
        for (int i = 0; i < 3; i++) begin
            o_ready[i] = rdy[i]; o_start[i] = mst[i]; o_valid[i] = ov[i];
            o_sel[i] = sel[i]; o_busy[i] = bsy[i];
            e_busy[i]  = m_pend[i];
            e_valid[i] = m_res[i];
            e_sel[i]   = m_rmul[i];
            e_start[i] = m_start[i];
            e_stall[i] = m_stall[i];
            e_ready[i] = f ? 1'b0 : m_pend[i] ? 1'b0 : m_res[i] ? r : 1'b1;
        end
        o_stall[0] = longint'(st0);
        o_stall[1] = longint'(st1);
        o_stall[2] = longint'(st2);
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                acc = v & e_ready[i];
                m_start[i] = acc & m;
                if (v && !e_ready[i] && m_stall[i] < smax[i]) m_stall[i]++;
                if (f) begin
                    m_pend[i] = 0; m_res[i] = 0;
                end else if (acc) begin
                    if (m) begin
                        m_pend[i] = 1; m_done[i] = cyc + lat[i] + 1; m_res[i] = 0;
                    end else begin
                        m_res[i] = 1; m_rmul[i] = 0;
                    end
                end else if (m_res[i] && r) begin
                    m_res[i] = 0;
                end
                if (m_pend[i] && (cyc + 1 == m_done[i])) begin
                    m_pend[i] = 0; m_res[i] = 1; m_rmul[i] = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) step(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        drain();
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        checks++;
        if (o_valid[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
            errors++; $display("FAIL reset_valid_busy got %0b%0b want 00", o_valid[0], o_busy[0]);
        end
        checks++;
        if (o_start[0] !== 1'b0 || o_sel[0] !== 1'b0) begin
            errors++; $display("FAIL reset_start_sel got %0b%0b want 00", o_start[0], o_sel[0]);
        end
        checks++;
        if (o_stall[0] !== 0) begin
            errors++; $display("FAIL reset_stall got %0d want 0", o_stall[0]);
        end
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 1);
            checks++;
            if (o_valid[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle k=%0d got v%0b b%0b r%0b want v0 b0 r1",
                         k, o_valid[0], o_busy[0], o_ready[0]);
            end
        end
    endtask

    task automatic test_alu_stream();
        drain();
        for (int k = 0; k < 6; k++) begin
            step(k < 4, 0, 0, 1);
            checks++;
            if (o_valid[0] !== bit'(k >= 1 && k <= 4)) begin
                errors++; $display("FAIL alu_valid k=%0d got %0b want %0b", k, o_valid[0], (k >= 1 && k <= 4));
            end
            checks++;
            if (o_ready[0] !== 1'b1) begin
                errors++; $display("FAIL alu_ready k=%0d got %0b want 1", k, o_ready[0]);
            end
            if (o_valid[0]) begin
                checks++;
                if (o_sel[0] !== 1'b0) begin
                    errors++; $display("FAIL alu_sel k=%0d got %0b want 0", k, o_sel[0]);
                end
            end
        end
        checks++;
        if (o_stall[0] !== 0) begin
            errors++; $display("FAIL alu_stall got %0d want 0", o_stall[0]);
        end
    endtask

    task automatic test_mul_latency();
        longint base;
        drain();
        base = o_stall[0];
        step(1, 1, 0, 1);
        checks++;
        if (o_ready[0] !== 1'b1) begin
            errors++; $display("FAIL mul_accept got %0b want 1", o_ready[0]);
        end
        for (int c = 1; c <= 6; c++) begin
            step(1, 0, 0, 1);
            if (c <= 5) begin
                checks++;
                if (o_start[0] !== bit'(c == 1) || o_busy[0] !== 1'b1 || o_ready[0] !== 1'b0 || o_valid[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_wait c=%0d got s%0b b%0b r%0b v%0b want s%0b b1 r0 v0",
                             c, o_start[0], o_busy[0], o_ready[0], o_valid[0], (c == 1));
                end
            end else begin
                checks++;
                if (o_valid[0] !== 1'b1 || o_sel[0] !== 1'b1 || o_ready[0] !== 1'b1 || o_busy[0] !== 1'b0 || o_start[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_result got v%0b s%0b r%0b b%0b st%0b want v1 s1 r1 b0 st0",
                             o_valid[0], o_sel[0], o_ready[0], o_busy[0], o_start[0]);
                end
                checks++;
                if (o_stall[0] - base !== 5) begin
                    errors++; $display("FAIL mul_stall got %0d want 5", o_stall[0] - base);
                end
            end
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_valid[0] !== 1'b1 || o_sel[0] !== 1'b0) begin
            errors++; $display("FAIL mul_then_alu got v%0b s%0b want v1 s0", o_valid[0], o_sel[0]);
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_valid[0] !== 1'b0) begin
            errors++; $display("FAIL mul_drain got %0b want 0", o_valid[0]);
        end
    endtask

    task automatic test_backpressure();
        longint base;
        drain();
        base = o_stall[0];
        step(1, 1, 0, 1);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            checks++;
            if (o_valid[0] !== 1'b1 || o_sel[0] !== 1'b1 || o_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold k=%0d got v%0b s%0b r%0b want v1 s1 r0", k, o_valid[0], o_sel[0], o_ready[0]);
            end
        end
        step(1, 0, 0, 1);
        checks++;
        if (o_ready[0] !== 1'b1 || o_valid[0] !== 1'b1 || o_sel[0] !== 1'b1) begin
            errors++; $display("FAIL bp_release got r%0b v%0b s%0b want r1 v1 s1", o_ready[0], o_valid[0], o_sel[0]);
        end
        checks++;
        if (o_stall[0] - base !== 3) begin
            errors++; $display("FAIL bp_stall got %0d want 3", o_stall[0] - base);
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_valid[0] !== 1'b1 || o_sel[0] !== 1'b0) begin
            errors++; $display("FAIL bp_next got v%0b s%0b want v1 s0", o_valid[0], o_sel[0]);
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_valid[0] !== 1'b0) begin
            errors++; $display("FAIL bp_drain got %0b want 0", o_valid[0]);
        end
    endtask

    task automatic test_flush();
        longint base;
        drain();
        step(1, 1, 0, 1);
        for (int c = 0; c < 3; c++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        checks++;
        if (o_busy[0] !== 1'b1) begin
            errors++; $display("FAIL flush_wait_busy got %0b want 1", o_busy[0]);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1);
            checks++;
            if (o_valid[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL flush_wait_after k=%0d got v%0b b%0b r%0b want v0 b0 r1", k, o_valid[0], o_busy[0], o_ready[0]);
            end
        end
        drain();
        base = o_stall[0];
        step(1, 1, 1, 1);
        checks++;
        if (o_ready[0] !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %0b want 0", o_ready[0]);
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_start[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_valid[0] !== 1'b0) begin
            errors++; $display("FAIL flush_mul_present got s%0b b%0b v%0b want 000", o_start[0], o_busy[0], o_valid[0]);
        end
        checks++;
        if (o_stall[0] - base !== 1) begin
            errors++; $display("FAIL flush_stall got %0d want 1", o_stall[0] - base);
        end
        step(1, 0, 0, 1);
        step(0, 0, 1, 0);
        checks++;
        if (o_valid[0] !== 1'b1) begin
            errors++; $display("FAIL flush_result_before got %0b want 1", o_valid[0]);
        end
        step(0, 0, 0, 0);
        checks++;
        if (o_valid[0] !== 1'b0) begin
            errors++; $display("FAIL flush_result_after got %0b want 0", o_valid[0]);
        end
    endtask

    task automatic test_mul_lat1();
        drain();
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        checks++;
        if (o_start[1] !== 1'b1 || o_busy[1] !== 1'b1 || o_valid[1] !== 1'b0) begin
            errors++; $display("FAIL lat1_start got s%0b b%0b v%0b want s1 b1 v0", o_start[1], o_busy[1], o_valid[1]);
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_valid[1] !== 1'b1 || o_sel[1] !== 1'b1 || o_busy[1] !== 1'b0) begin
            errors++; $display("FAIL lat1_result got v%0b s%0b b%0b want v1 s1 b0", o_valid[1], o_sel[1], o_busy[1]);
        end
        step(0, 0, 0, 1);
        checks++;
        if (o_valid[1] !== 1'b0) begin
            errors++; $display("FAIL lat1_drain got %0b want 0", o_valid[1]);
        end
    endtask

    task automatic test_stall_sat();
        longint base;
        drain();
        base = o_stall[0];
        for (int k = 0; k < 20; k++) step(1, 0, 1, 1);
        step(0, 0, 0, 1);
        checks++;
        if (o_stall[2] !== 15) begin
            errors++; $display("FAIL stall_sat4 got %0d want 15", o_stall[2]);
        end
        checks++;
        if (o_stall[0] - base !== 20) begin
            errors++; $display("FAIL stall_count32 got %0d want 20", o_stall[0] - base);
        end
    endtask

    task automatic test_random();
        bit v, m, f, r, rs;
        for (int n = 0; n < 500; n++) begin
            v  = ($urandom_range(0, 99) < 70);
            m  = ($urandom_range(0, 99) < 35);
            f  = ($urandom_range(0, 99) < 5);
            r  = ($urandom_range(0, 99) < 70);
            rs = ($urandom_range(0, 199) != 0);
            step(v, m, f, r, rs);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (o_ready[i] !== e_ready[i]) begin
                    errors++; $display("FAIL rnd_ready[%0d] cyc %0d got %0b want %0b", i, cyc, o_ready[i], e_ready[i]);
                end
                checks++;
                if (o_start[i] !== e_start[i]) begin
                    errors++; $display("FAIL rnd_start[%0d] cyc %0d got %0b want %0b", i, cyc, o_start[i], e_start[i]);
                end
                checks++;
                if (o_valid[i] !== e_valid[i]) begin
                    errors++; $display("FAIL rnd_valid[%0d] cyc %0d got %0b want %0b", i, cyc, o_valid[i], e_valid[i]);
                end
                checks++;
                if (o_busy[i] !== e_busy[i]) begin
                    errors++; $display("FAIL rnd_busy[%0d] cyc %0d got %0b want %0b", i, cyc, o_busy[i], e_busy[i]);
                end
                checks++;
                if (o_stall[i] !== e_stall[i]) begin
                    errors++; $display("FAIL rnd_stall[%0d] cyc %0d got %0d want %0d", i, cyc, o_stall[i], e_stall[i]);
                end
                if (e_valid[i]) begin
                    checks++;
                    if (o_sel[i] !== e_sel[i]) begin
                        errors++; $display("FAIL rnd_sel[%0d] cyc %0d got %0b want %0b", i, cyc, o_sel[i], e_sel[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_is_mul = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        test_reset();
        test_alu_stream();
        test_mul_latency();
        test_backpressure();
        test_flush();
        test_mul_lat1();
        test_stall_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
